// File: rtl/bitonic_sort_seq_ctrl.sv
// Sequential bitonic sorter that shares a single compare-exchange unit over every stage of an N-key network.
// Define BITONIC_DESCEND_EN to invert every comparison, which produces descending output.
module bitonic_sort_seq_ctrl #(
    parameter int LOG2N = 2,
    parameter int W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W*(1<<LOG2N)-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W*(1<<LOG2N)-1:0]      out_data,
    output logic                         busy,
    output logic [7:0]                   swap_count
);

    localparam int N  = 1 << LOG2N;
    localparam int IW = LOG2N;
    localparam int PW = (LOG2N > 1) ? LOG2N - 1 : 1;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t         state, next_state;
    logic           armed;
    logic [W-1:0]   keys [N];
    logic [2:0]     stage;
    logic [2:0]     sub;
    logic [PW-1:0]  pair;

    logic [IW-1:0]  pair_ext, lo_mask, lo_idx, hi_idx;
    logic [IW:0]    k_mask;
    logic [W-1:0]   key_lo, key_hi;
    logic           descending, do_swap, last_pair, last_op, load;

    // stage holds log2(k)-1 and sub holds log2(j), so all counters start at zero on a load.
    always_comb begin
        pair_ext   = IW'(pair);
        lo_mask    = IW'((1 << sub) - 1);
        lo_idx     = ((pair_ext & ~lo_mask) << 1) | (pair_ext & lo_mask);
        hi_idx     = lo_idx | IW'(1 << sub);
        k_mask     = (IW+1)'(32'd2 << stage);
        descending = |({1'b0, lo_idx} & k_mask);
        key_lo     = keys[lo_idx];
        key_hi     = keys[hi_idx];
`ifdef BITONIC_DESCEND_EN
        do_swap    = descending ? (key_lo > key_hi) : (key_lo < key_hi);
`else
        do_swap    = descending ? (key_lo < key_hi) : (key_lo > key_hi);
`endif
        last_pair  = (pair == PW'(N/2 - 1));
        last_op    = last_pair && (sub == 3'd0) && (stage == 3'(LOG2N - 1));
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (in_valid && armed) begin
                    load       = 1'b1;
                    next_state = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (last_op) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load       = 1'b1;
                        next_state = SORT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        if (state == DONE) begin
            for (int e = 0; e < N; e++) begin
                out_data[e*W +: W] = keys[e];
            end
        end
    end

    // armed keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= 3'd0;
            sub   <= 3'd0;
            pair  <= '0;
        end else if (load) begin
            stage <= 3'd0;
            sub   <= 3'd0;
            pair  <= '0;
        end else if ((state == SORT) && !last_op) begin
            if (last_pair) begin
                pair <= '0;
                if (sub == 3'd0) begin
                    stage <= stage + 3'd1;
                    sub   <= stage + 3'd1;
                end else begin
                    sub <= sub - 3'd1;
                end
            end else begin
                pair <= pair + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < N; e++) begin
                keys[e] <= '0;
            end
        end else if (load) begin
            for (int e = 0; e < N; e++) begin
                keys[e] <= in_data[e*W +: W];
            end
        end else if ((state == SORT) && do_swap) begin
            keys[lo_idx] <= key_hi;
            keys[hi_idx] <= key_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_count <= 8'd0;
        end else if (load) begin
            swap_count <= 8'd0;
        end else if ((state == SORT) && do_swap && (swap_count != 8'hFF)) begin
            swap_count <= swap_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_seq_ctrl.sv
// Self-checking bench for bitonic_sort_seq_ctrl with N=4, W=4; follows BITONIC_DESCEND_EN when defined.
module tb_bitonic_sort_seq_ctrl;

    localparam int LOG2N = 2;
    localparam int W     = 4;
    localparam int NOPS  = 6;

`ifdef BITONIC_DESCEND_EN
    localparam logic [15:0] EXP_SORTED = 16'h0123;
    localparam logic [15:0] EXP_F0A5   = 16'h05AF;
`else
    localparam logic [15:0] EXP_SORTED = 16'h3210;
    localparam logic [15:0] EXP_F0A5   = 16'hFA50;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  swap_count;

    int total = 0;
    int bad   = 0;
    logic [23:0] sb [$];

    always #5 clk = ~clk;

    bitonic_sort_seq_ctrl #(.LOG2N(LOG2N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .swap_count(swap_count)
    );

    // Reference network written in the classic i^j form; returns {swap count, sorted keys}.
    function automatic logic [23:0] model(input logic [15:0] v);
        logic [3:0] k [4];
        logic [7:0] cnt;
        logic [15:0] r;
        cnt = 8'd0;
        for (int e = 0; e < 4; e++) k[e] = v[e*4 +: 4];
        for (int kk = 2; kk <= 4; kk *= 2) begin
            for (int jj = kk / 2; jj > 0; jj /= 2) begin
                for (int i = 0; i < 4; i++) begin
                    int l;
                    logic up, sw;
                    logic [3:0] t;
                    l = i ^ jj;
                    if (l > i) begin
                        up = ((i & kk) == 0);
`ifdef BITONIC_DESCEND_EN
                        sw = up ? (k[i] < k[l]) : (k[i] > k[l]);
`else
                        sw = up ? (k[i] > k[l]) : (k[i] < k[l]);
`endif
                        if (sw) begin
                            t = k[i]; k[i] = k[l]; k[l] = t;
                            if (cnt != 8'hFF) cnt = cnt + 8'd1;
                        end
                    end
                end
            end
        end
        for (int e = 0; e < 4; e++) r[e*4 +: 4] = k[e];
        return {cnt, r};
    endfunction

    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL accept: in_ready=%0b never seen, required 1", in_ready);
        end else begin
            sb.push_back(model(v));
        end
    endtask

    task automatic collect(input string name, output logic [15:0] exp_d, output logic [7:0] exp_c);
        int busy_cnt;
        logic [23:0] exp;
        busy_cnt = 0;
        for (int c = 0; c < 100 && !out_valid; c++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        exp = 24'h0;
        if (sb.size() != 0) exp = sb.pop_front();
        exp_d = exp[15:0];
        exp_c = exp[23:16];
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_valid: out_valid=%0b required 1", name, out_valid);
        end
        total++;
        if (out_data !== exp_d) begin
            bad++;
            $display("[TB] FAIL %s_data: got %h required %h", name, out_data, exp_d);
        end
        total++;
        if (swap_count !== exp_c) begin
            bad++;
            $display("[TB] FAIL %s_swaps: got %0d required %0d", name, swap_count, exp_c);
        end
        total++;
        if (busy_cnt != NOPS) begin
            bad++;
            $display("[TB] FAIL %s_busy: got %0d cycles required %0d", name, busy_cnt, NOPS);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({in_ready, out_valid, busy, out_data, swap_count} !== 27'h0) begin
            bad++;
            $display("[TB] FAIL %s: in_ready=%0b out_valid=%0b busy=%0b out_data=%h swap_count=%0d required all 0",
                     name, in_ready, out_valid, busy, out_data, swap_count);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1 check_zero("reset_outputs");
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] d;
        logic [7:0]  c;
        send(16'h0213);
        collect("basic_0213", d, c);
        total++;
        if (out_data !== EXP_SORTED) begin
            bad++;
            $display("[TB] FAIL basic_0213_const: got %h required %h", out_data, EXP_SORTED);
        end
`ifndef BITONIC_DESCEND_EN
        total++;
        if (swap_count !== 8'd3) begin
            bad++;
            $display("[TB] FAIL basic_0213_count: got %0d required 3", swap_count);
        end
`endif
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_drain: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        send(16'h3210);
        collect("basic_3210", d, c);
`ifndef BITONIC_DESCEND_EN
        total++;
        if (swap_count !== 8'd2) begin
            bad++;
            $display("[TB] FAIL basic_3210_count: got %0d required 2", swap_count);
        end
`endif
        @(posedge clk); #1;
        send(16'h5555);
        collect("basic_5555", d, c);
        total++;
        if (out_data !== 16'h5555 || swap_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL basic_5555_const: got %h/%0d required 5555/0", out_data, swap_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic [7:0]  c;
        out_ready = 1'b0;
        send(16'h0213);
        collect("bp_first", d, c);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== d || swap_count !== c) begin
                bad++;
                $display("[TB] FAIL bp_hold: cycle %0d got %0b/%h/%0d required 1/%h/%0d",
                         i, out_valid, out_data, swap_count, d, c);
            end
        end
        in_data   = 16'hF0A5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_ready: in_ready=%0b required 1", in_ready);
        end
        sb.push_back(model(16'hF0A5));
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_handoff: busy=%0b out_valid=%0b required 1/0", busy, out_valid);
        end
        collect("b2b_second", d, c);
        total++;
        if (out_data !== EXP_F0A5) begin
            bad++;
            $display("[TB] FAIL b2b_const: got %h required %h", out_data, EXP_F0A5);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sort;
        logic [15:0] d;
        logic [7:0]  c;
        send(16'h0213);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_zero("midsort_reset");
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'h1032);
        collect("midsort_next", d, c);
        total++;
        if (out_data !== EXP_SORTED) begin
            bad++;
            $display("[TB] FAIL midsort_const: got %h required %h", out_data, EXP_SORTED);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [15:0] d;
        logic [7:0]  c;
        for (int n = 0; n < 6; n++) begin
            send(16'($urandom));
            collect("random", d, c);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_reset_mid_sort;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_seq_ctrl.md
Name: bitonic_sort_seq_ctrl

Overview:
Iterative bitonic sort engine that shares one compare-exchange (CE) unit across all stages of an N-key bitonic network. It performs one CE per clock.
It accepts a full key vector over a valid/ready handshake and sequences the stage, substage and pair counters. It returns the vector sorted ascending, plus a swap count.
It is the sequential, area-shared counterpart of the fully combinational sort netlists; it sits between a key producer and a consumer.

Parameters:
LOG2N, 2, log2 of key count; N = 2^LOG2N; legal range 1..5
W, 4, key width in bits (unsigned)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  engine can accept a vector this cycle
in_data  in  N*W  key e at bits [e*W +: W], e = 0..N-1
out_valid  out  1  sorted vector available
out_ready  in  1  consumer accepts the vector
out_data  out  N*W  sorted keys; key e at [e*W +: W]; e=0 is smallest
busy  out  1  high in SORT state
swap_count  out  8  number of swaps in the last sort; saturates at 255

Behaviour:
- Reset: one clock, async active-high. While rst is high:
  - state = IDLE; key registers = 0; all counters = 0.
  - in_ready=0, out_valid=0, busy=0, out_data=0, swap_count=0.
  - in_ready rises in the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1. in_valid&in_ready latches in_data into key regs, clears swap_count and counters, and moves to SORT.
  - SORT: busy=1, in_ready=0, out_valid=0. One CE per edge.
  - DONE: out_valid=1; out_data = key regs, held stable until taken.
    - in_ready = out_ready. out_valid&out_ready with in_valid=0 -> IDLE.
    - out_valid&out_ready with in_valid=1 -> load the new vector and go straight to SORT (back-to-back, no bubble).
- Sequence:
  - Outer k = 2,4,...,N; inner j = k/2 down to 1; pair index p = 0..N/2-1.
  - Lower index i = p with a 0 inserted at bit position log2(j); partner = i^j.
  - Direction: ascending if (i & k)==0, else descending. When k=N, every pair is ascending.
  - Ascending: swap if key[i] > key[partner]. Descending: swap if key[i] < key[partner]. Equal keys are never swapped.
  - Each swap increments swap_count, saturating at 255.
- Latency:
  - NOPS = (N/2)*LOG2N*(LOG2N+1)/2 (N=4 -> 6; N=8 -> 24).
  - Accept edge E0; CE edges E1..E_NOPS; out_valid is high right after E_NOPS.
  - Input-accept to output-valid = NOPS+1 cycles.
- Counter wrap: the last CE (k=N, j=1, p=N/2-1) transitions to DONE. Counters reset to 0 on the next load.
- Backpressure: out_ready low in DONE holds out_data and swap_count indefinitely.
- in_valid during SORT: ignored, no effect; the producer must hold the vector.
- Reset mid-SORT: sort is aborted and the partial result discarded; all outputs return to reset values.
- swap_count is valid whenever out_valid=1 and is held until the next load.

Optional Feature:
- Macro: BITONIC_DESCEND_EN.
- Defined: all comparisons are inverted (the swap condition > becomes <, and < becomes >). Final output is descending; e=0 is the largest key. Sequence, latency and swap counting are otherwise identical.
- Undefined: ascending output as specified above.

Test Plan:
- N=4, W=4: reset asserted mid-cycle, then released -> during reset all outputs 0; in_ready=1 the cycle after release.
- in_data=16'h0213 (keys 3,1,2,0) accepted at E0 -> out_valid after E6; out_data=16'h3210; swap_count=3; busy high for exactly 6 cycles.
- in_data=16'h3210 (already sorted) -> out_data=16'h3210, swap_count=2. in_data=16'h5555 -> out_data=16'h5555, swap_count=0.
- out_ready held low for 10 cycles in DONE -> out_valid, out_data and swap_count stable. Then out_ready=1 with in_valid=1 and in_data=16'hF0A5 -> same-edge handoff; next result 16'hFA50 after NOPS edges.
- rst pulsed at the 3rd SORT cycle of 16'h0213 -> all outputs 0 immediately. Next vector 16'h1032 -> out_data=16'h3210; the aborted sort leaves no residue.
- BITONIC_DESCEND_EN defined, in_data=16'h0213 -> out_data=16'h0123; same 6-cycle latency.
